// File: rtl/seq_detector_compare.sv
// Moore/Mealy detector pair for one serial pattern, stepped by a strobe.
// Per-machine saturating counts and a sticky cross-check flag.
module seq_detector_compare #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 8,
  localparam int SW = $clog2(PAT_LEN + 1)
) (
  input  logic             Clock50M,
  input  logic             Reset,
  input  logic             Step,
  input  logic             A,
  output logic             Z_moore,
  output logic [SW-1:0]    S_moore,
  output logic             Z_mealy,
  output logic [SW-1:0]    S_mealy,
  output logic [CNT_W-1:0] Cnt_moore,
  output logic [CNT_W-1:0] Cnt_mealy,
  output logic             Mismatch
);

  localparam int NS = 1 << SW;

  // Longest prefix of PATTERN that is a suffix of (prefix_k, a).
  function automatic int delta_f(input int k, input bit a);
    int res;
    int i;
    bit ok;
    bit sb;
    res = 0;
    if (k < PAT_LEN) begin
      for (int j = 1; j <= PAT_LEN; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int m = 0; m < PAT_LEN; m++) begin
            if (m < j) begin
              i = k + 1 - j + m;
              sb = (i == k) ? a : PATTERN[PAT_LEN-1-i];
              if (sb != PATTERN[PAT_LEN-1-m]) ok = 1'b0;
            end
          end
          if (ok) res = j;
        end
      end
    end
    return res;
  endfunction

  // Longest proper suffix of PATTERN that is also a prefix.
  function automatic int fail_f();
    int res;
    bit ok;
    res = 0;
    for (int j = 1; j < PAT_LEN; j++) begin
      ok = 1'b1;
      for (int m = 0; m < PAT_LEN; m++) begin
        if (m < j) begin
          if (PATTERN[j-1-m] != PATTERN[PAT_LEN-1-m]) ok = 1'b0;
        end
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  localparam int F = fail_f();
  localparam logic [SW-1:0] LAST  = SW'(PAT_LEN);
  localparam logic [SW-1:0] MLAST = SW'(PAT_LEN - 1);
  localparam logic [SW-1:0] RST_K = (OVERLAP != 0) ? SW'(F) : '0;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam logic [SW-1:0] D0 = SW'(delta_f(k, 1'b0));
    localparam logic [SW-1:0] D1 = SW'(delta_f(k, 1'b1));
    assign nxt0[k] = D0;
    assign nxt1[k] = D1;
  end

  logic [SW-1:0]    s_moore_q, s_moore_d;
  logic [SW-1:0]    s_mealy_q, s_mealy_d;
  logic             z_moore_q, z_moore_d;
  logic [CNT_W-1:0] cnt_moore_q, cnt_moore_d;
  logic [CNT_W-1:0] cnt_mealy_q, cnt_mealy_d;
  logic             mismatch_q, mismatch_d;

  logic [SW-1:0] moore_src;
  logic [SW-1:0] moore_nx;
  logic [SW-1:0] mealy_nx;
  logic          moore_hit;
  logic          z_mealy;

  // Next-state, detect and counter logic for both machines.
  always_comb begin
    s_moore_d   = s_moore_q;
    s_mealy_d   = s_mealy_q;
    cnt_moore_d = cnt_moore_q;
    cnt_mealy_d = cnt_mealy_q;
    mismatch_d  = mismatch_q;
    moore_src   = (s_moore_q == LAST) ? RST_K : s_moore_q;
    moore_nx    = A ? nxt1[moore_src] : nxt0[moore_src];
    moore_hit   = Step && (moore_nx == LAST);
    z_mealy     = Step && (s_mealy_q == MLAST) &&
                  (A == PATTERN[0]);
    mealy_nx    = z_mealy ? RST_K :
                  (A ? nxt1[s_mealy_q] : nxt0[s_mealy_q]);
    if (Step) begin
      s_moore_d = moore_nx;
      s_mealy_d = mealy_nx;
      if (moore_hit != z_mealy) mismatch_d = 1'b1;
    end
    if (moore_hit && cnt_moore_q != CMAX)
      cnt_moore_d = cnt_moore_q + 1'b1;
    if (z_mealy && cnt_mealy_q != CMAX)
      cnt_mealy_d = cnt_mealy_q + 1'b1;
    z_moore_d = (s_moore_d == LAST);
  end

  // State, count and flag registers; reset wins over a step.
  always_ff @(posedge Clock50M) begin
    if (Reset) begin
      s_moore_q   <= '0;
      s_mealy_q   <= '0;
      z_moore_q   <= 1'b0;
      cnt_moore_q <= '0;
      cnt_mealy_q <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      s_moore_q   <= s_moore_d;
      s_mealy_q   <= s_mealy_d;
      z_moore_q   <= z_moore_d;
      cnt_moore_q <= cnt_moore_d;
      cnt_mealy_q <= cnt_mealy_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign Z_moore   = z_moore_q;
  assign S_moore   = s_moore_q;
  assign Z_mealy   = z_mealy;
  assign S_mealy   = s_mealy_q;
  assign Cnt_moore = cnt_moore_q;
  assign Cnt_mealy = cnt_mealy_q;
  assign Mismatch  = mismatch_q;

endmodule

// File: tb/tb_seq_detector_compare.sv
// Directed bench for seq_detector_compare: five parameterisations
// share one stimulus stream; expectations are hand-derived.
module tb_seq_detector_compare;

  logic clk = 1'b0;
  logic rst;
  logic step;
  logic a;

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // default 1011 overlapping
  logic       ov_zmo, ov_zme, ov_mm;
  logic [2:0] ov_smo, ov_sme;
  logic [7:0] ov_cmo, ov_cme;
  // 1011 non-overlapping
  logic       no_zmo, no_zme, no_mm;
  logic [2:0] no_smo, no_sme;
  logic [7:0] no_cmo, no_cme;
  // 111 overlapping
  logic       r3o_zmo, r3o_zme, r3o_mm;
  logic [1:0] r3o_smo, r3o_sme;
  logic [7:0] r3o_cmo, r3o_cme;
  // 111 non-overlapping
  logic       r3n_zmo, r3n_zme, r3n_mm;
  logic [1:0] r3n_smo, r3n_sme;
  logic [7:0] r3n_cmo, r3n_cme;
  // 111 overlapping, 2-bit counters
  logic       sat_zmo, sat_zme, sat_mm;
  logic [1:0] sat_smo, sat_sme;
  logic [1:0] sat_cmo, sat_cme;

  seq_detector_compare u_ov (
    .Clock50M(clk), .Reset(rst), .Step(step), .A(a),
    .Z_moore(ov_zmo), .S_moore(ov_smo),
    .Z_mealy(ov_zme), .S_mealy(ov_sme),
    .Cnt_moore(ov_cmo), .Cnt_mealy(ov_cme),
    .Mismatch(ov_mm)
  );

  seq_detector_compare #(.OVERLAP(0)) u_no (
    .Clock50M(clk), .Reset(rst), .Step(step), .A(a),
    .Z_moore(no_zmo), .S_moore(no_smo),
    .Z_mealy(no_zme), .S_mealy(no_sme),
    .Cnt_moore(no_cmo), .Cnt_mealy(no_cme),
    .Mismatch(no_mm)
  );

  seq_detector_compare #(
    .PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1)
  ) u_r3o (
    .Clock50M(clk), .Reset(rst), .Step(step), .A(a),
    .Z_moore(r3o_zmo), .S_moore(r3o_smo),
    .Z_mealy(r3o_zme), .S_mealy(r3o_sme),
    .Cnt_moore(r3o_cmo), .Cnt_mealy(r3o_cme),
    .Mismatch(r3o_mm)
  );

  seq_detector_compare #(
    .PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(0)
  ) u_r3n (
    .Clock50M(clk), .Reset(rst), .Step(step), .A(a),
    .Z_moore(r3n_zmo), .S_moore(r3n_smo),
    .Z_mealy(r3n_zme), .S_mealy(r3n_sme),
    .Cnt_moore(r3n_cmo), .Cnt_mealy(r3n_cme),
    .Mismatch(r3n_mm)
  );

  seq_detector_compare #(
    .PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2)
  ) u_sat (
    .Clock50M(clk), .Reset(rst), .Step(step), .A(a),
    .Z_moore(sat_zmo), .S_moore(sat_smo),
    .Z_mealy(sat_zme), .S_mealy(sat_sme),
    .Cnt_moore(sat_cmo), .Cnt_mealy(sat_cme),
    .Mismatch(sat_mm)
  );

  logic zc_ov, zc_no, zc_r3o, zc_r3n;

  task automatic do_step(input logic av);
    @(negedge clk);
    step = 1'b1;
    a = av;
    #1;
    zc_ov  = ov_zme;
    zc_no  = no_zme;
    zc_r3o = r3o_zme;
    zc_r3n = r3n_zme;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic bits7 [7] = '{1, 0, 1, 1, 0, 1, 1};
  logic e_ov7 [7] = '{0, 0, 0, 1, 0, 0, 1};
  logic e_no7 [7] = '{0, 0, 0, 1, 0, 0, 0};
  logic e_r3o [5] = '{0, 0, 1, 1, 1};
  logic e_r3n [5] = '{0, 0, 1, 0, 0};

  initial begin
    rst = 1'b1;
    step = 1'b0;
    a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_smoore", ov_smo, 0);
    chk("rst_smealy", ov_sme, 0);
    chk("rst_zmoore", ov_zmo, 0);
    chk("rst_zmealy", ov_zme, 0);
    chk("rst_cnt_moore", ov_cmo, 0);
    chk("rst_cnt_mealy", ov_cme, 0);
    chk("rst_mismatch", ov_mm, 0);

    // 1011 stream, overlapping vs non-overlapping
    for (int i = 0; i < 7; i++) begin
      do_step(bits7[i]);
      chk($sformatf("ov_zmealy_s%0d", i + 1), zc_ov, e_ov7[i]);
      chk($sformatf("ov_zmoore_s%0d", i + 1), ov_zmo, e_ov7[i]);
      chk($sformatf("no_zmealy_s%0d", i + 1), zc_no, e_no7[i]);
      chk($sformatf("no_zmoore_s%0d", i + 1), no_zmo, e_no7[i]);
    end
    chk("ov_zmealy_oneshot", ov_zme, 0);
    chk("ov_smoore_end", ov_smo, 4);
    chk("ov_smealy_end", ov_sme, 1);
    chk("ov_cnt_moore", ov_cmo, 2);
    chk("ov_cnt_mealy", ov_cme, 2);
    chk("ov_mismatch", ov_mm, 0);
    chk("no_smoore_end", no_smo, 1);
    chk("no_smealy_end", no_sme, 1);
    chk("no_cnt_moore", no_cmo, 1);
    chk("no_cnt_mealy", no_cme, 1);
    chk("no_mismatch", no_mm, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ov_zmoore_holds", ov_zmo, 1);

    // repeated ones on the 3-bit machines
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_step(1'b1);
      chk($sformatf("r3o_zmealy_s%0d", i + 1), zc_r3o, e_r3o[i]);
      chk($sformatf("r3n_zmealy_s%0d", i + 1), zc_r3n, e_r3n[i]);
    end
    chk("r3o_cnt_moore", r3o_cmo, 3);
    chk("r3o_cnt_mealy", r3o_cme, 3);
    chk("r3o_smoore", r3o_smo, 3);
    chk("r3n_cnt_moore", r3n_cmo, 1);
    chk("r3n_cnt_mealy", r3n_cme, 1);
    chk("r3n_smoore", r3n_smo, 2);
    chk("sat_cnt_moore5", sat_cmo, 3);
    chk("sat_cnt_mealy5", sat_cme, 3);
    do_step(1'b1);
    chk("sat_cnt_moore6", sat_cmo, 3);
    chk("sat_cnt_mealy6", sat_cme, 3);
    chk("sat_mismatch", sat_mm, 0);
    chk("r3o_cnt_moore6", r3o_cmo, 4);
    chk("r3n_cnt_mealy6", r3n_cme, 2);
    chk("r3n_mismatch", r3n_mm, 0);

    // hold with no step, then reset coincident with a step
    do_reset();
    do_step(1'b1);
    do_step(1'b0);
    do_step(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = ~a;
    end
    @(posedge clk);
    #1;
    chk("hold_smoore", ov_smo, 3);
    chk("hold_smealy", ov_sme, 3);
    chk("hold_cnt_moore", ov_cmo, 0);
    chk("hold_cnt_mealy", ov_cme, 0);
    @(negedge clk);
    rst = 1'b1;
    step = 1'b1;
    a = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step = 1'b0;
    chk("rs_smoore", ov_smo, 0);
    chk("rs_smealy", ov_sme, 0);
    chk("rs_zmoore", ov_zmo, 0);
    chk("rs_cnt_moore", ov_cmo, 0);
    chk("rs_cnt_mealy", ov_cme, 0);
    chk("rs_mismatch", ov_mm, 0);
    do_step(1'b1);
    chk("post_smoore", ov_smo, 1);
    chk("post_smealy", ov_sme, 1);
    chk("post_zmealy", zc_ov, 0);
    chk("post_zmoore", ov_zmo, 0);

    // corrupt the Mealy state to provoke the cross-check
    do_reset();
    do_step(1'b1);
    do_step(1'b0);
    do_step(1'b1);
    chk("mm_before", ov_mm, 0);
    @(negedge clk);
    force u_ov.s_mealy_q = '0;
    step = 1'b1;
    a = 1'b1;
    #1;
    zc_ov = ov_zme;
    @(posedge clk);
    #1;
    step = 1'b0;
    release u_ov.s_mealy_q;
    chk("mm_zmealy", zc_ov, 0);
    chk("mm_set", ov_mm, 1);
    chk("mm_cnt_moore", ov_cmo, 1);
    chk("mm_cnt_mealy", ov_cme, 0);
    do_step(1'b0);
    do_step(1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mm_sticky", ov_mm, 1);
    do_reset();
    chk("mm_cleared", ov_mm, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
